// File: rtl/miso_capture_pkg.sv
// Shared constants and state type for the oversampled MISO capture path.
//   CAPTURE_LEN : samples collected per SPI frame
//   WORD_LEN    : data bits per SPI word
//   OVERSAMPLE  : samples taken per SCLK bit
//   CNT_W       : sample counter width (holds 0..CAPTURE_LEN)
package miso_capture_pkg;

    localparam int unsigned CAPTURE_LEN = 74;
    localparam int unsigned WORD_LEN    = 16;
    localparam int unsigned OVERSAMPLE  = 4;
    localparam int unsigned CNT_W       = 7;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } cap_state_e;

endpackage

// File: rtl/miso_sync_chain.sv
// Single-bit flip-flop synchroniser for one raw MISO pin.
//   dataclk : destination clock
//   reset_n : asynchronous active-low reset, clears every stage
//   d       : raw asynchronous input
//   q       : d delayed by SYNC_STAGES dataclk cycles (legal depth 2..4)
module miso_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic dataclk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift chain; stage 0 is the metastability-exposed flop.
    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/miso_oversample_capture.sv
// Oversampled MISO capture: synchronises each lane, collects 74 samples per
// SPI frame into a per-lane shift register and publishes them on completion.
//   dataclk       : sample clock (4x SCLK)
//   reset_n       : asynchronous active-low reset
//   frame_start   : one-cycle pulse, first sample cycle of a frame
//   sample_en     : sampling/counting enable
//   miso_in       : raw MISO pins, one per lane
//   overrun_clr   : clears the sticky overrun flag
//   miso4x        : held samples, lane k at [74k+73:74k], bit 0 oldest
//   capture_valid : one-cycle strobe, miso4x updated on the same edge
//   busy          : frame capture in progress
//   overrun       : sticky, a frame was aborted by a new frame_start
module miso_oversample_capture
    import miso_capture_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                             dataclk,
    input  logic                             reset_n,
    input  logic                             frame_start,
    input  logic                             sample_en,
    input  logic [NUM_LANES-1:0]             miso_in,
    input  logic                             overrun_clr,
    output logic [NUM_LANES*CAPTURE_LEN-1:0] miso4x,
    output logic                             capture_valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam int unsigned VEC_W = NUM_LANES * CAPTURE_LEN;

    logic [NUM_LANES-1:0] miso_s;
    logic [VEC_W-1:0]     shreg_q;
    logic [VEC_W-1:0]     shreg_next_c;

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_d, overrun_d, valid_d;
    logic             shift_c, load_c;

    // Per-lane synchroniser and next shift value (newest sample enters at the top).
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        miso_sync_chain #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .dataclk (dataclk),
            .reset_n (reset_n),
            .d       (miso_in[k]),
            .q       (miso_s[k])
        );

        assign shreg_next_c[k*CAPTURE_LEN +: CAPTURE_LEN] =
            {miso_s[k], shreg_q[k*CAPTURE_LEN+1 +: CAPTURE_LEN-1]};
    end

    // Next-state, counter and flag logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy;
        overrun_d = overrun & ~overrun_clr;
        valid_d   = 1'b0;
        load_c    = 1'b0;
        shift_c   = sample_en & ((state_q == CAPTURE) | frame_start);

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = CAPTURE;
                    busy_d  = 1'b1;
                    count_d = sample_en ? CNT_W'(1) : CNT_W'(0);
                end
            end
            CAPTURE: begin
                if (sample_en && (count_q == CNT_W'(CAPTURE_LEN - 1))) begin
                    // 74th sample closes the frame even if a new one starts now;
                    // that sample belongs only to the finishing frame.
                    load_c  = 1'b1;
                    valid_d = 1'b1;
                    count_d = CNT_W'(0);
                    if (!frame_start) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (frame_start) begin
                    // Abort: restart the count, set wins over a same-cycle clear.
                    count_d   = sample_en ? CNT_W'(1) : CNT_W'(0);
                    overrun_d = 1'b1;
                end else if (sample_en) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                count_d = CNT_W'(0);
            end
        endcase
    end

    // State, control and flag registers.
    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            capture_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            busy          <= busy_d;
            overrun       <= overrun_d;
            capture_valid <= valid_d;
        end
    end

    // Sample shift registers and held output vector.
    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
            miso4x  <= '0;
        end else begin
            if (shift_c) begin
                shreg_q <= shreg_next_c;
            end
            if (load_c) begin
                miso4x <= shreg_next_c;
            end
        end
    end

endmodule

// File: tb/tb_miso_oversample_capture.sv
module tb_miso_oversample_capture;

    localparam int NL  = 2;
    localparam int SL  = 2;
    localparam int LEN = 74;
    localparam int W   = NL * LEN;

    logic          dataclk;
    logic          reset_n;
    logic          frame_start;
    logic          sample_en;
    logic [NL-1:0] miso_in;
    logic          overrun_clr;
    logic [W-1:0]  miso4x;
    logic          capture_valid;
    logic          busy;
    logic          overrun;

    miso_oversample_capture #(
        .NUM_LANES   (NL),
        .SYNC_STAGES (SL)
    ) dut (
        .dataclk       (dataclk),
        .reset_n       (reset_n),
        .frame_start   (frame_start),
        .sample_en     (sample_en),
        .miso_in       (miso_in),
        .overrun_clr   (overrun_clr),
        .miso4x        (miso4x),
        .capture_valid (capture_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial dataclk = 1'b0;
    always #5 dataclk = ~dataclk;

    int tests = 0;
    int fails = 0;

    // Reference model state: pin history, samples of the open frame, expected outputs.
    logic [NL-1:0] syncq[$];
    logic [NL-1:0] samples[$];
    bit            m_active;
    logic [W-1:0]  exp_miso4x;
    logic          exp_valid, exp_busy, exp_overrun;

    int v_cnt, v_first, v_last, busy_fall;
    bit ovr_seen;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        syncq.delete();
        for (int i = 0; i < SL; i++) syncq.push_back('0);
        samples.delete();
        m_active    = 0;
        exp_miso4x  = '0;
        exp_valid   = 1'b0;
        exp_busy    = 1'b0;
        exp_overrun = 1'b0;
    endtask

    // One dataclk edge of the specified behaviour, using the inputs seen at that edge.
    task automatic model_step();
        logic [NL-1:0] ms;
        bit take, abort;
        if (!reset_n) begin
            model_reset();
            return;
        end
        ms = syncq[0];
        syncq.delete(0);
        syncq.push_back(miso_in);
        exp_valid = 1'b0;
        abort     = 0;
        take      = sample_en && (m_active || frame_start);
        if (m_active && take && samples.size() == LEN - 1) begin
            samples.push_back(ms);
            for (int i = 0; i < LEN; i++)
                for (int k = 0; k < NL; k++)
                    exp_miso4x[k*LEN + i] = samples[i][k];
            exp_valid = 1'b1;
            samples.delete();
            m_active = frame_start;
        end else if (frame_start) begin
            abort = m_active;
            samples.delete();
            m_active = 1;
            if (sample_en) samples.push_back(ms);
        end else if (take) begin
            samples.push_back(ms);
        end
        if (abort) exp_overrun = 1'b1;
        else if (overrun_clr) exp_overrun = 1'b0;
        exp_busy = m_active;
    endtask

    task automatic tick();
        @(posedge dataclk);
        model_step();
        #1;
        check("valid", W'(capture_valid), W'(exp_valid));
        check("busy", W'(busy), W'(exp_busy));
        check("overrun", W'(overrun), W'(exp_overrun));
        check("miso4x", miso4x, exp_miso4x);
    endtask

    task automatic idle_ticks(input int n);
        frame_start = 1'b0;
        sample_en   = 1'b1;
        miso_in     = '0;
        overrun_clr = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives words MSB-first from cycle 0, frame_start at cycle 2 (and optionally fs2).
    task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1, input int hold,
                             input bit gap, input int fs2, input int ncyc);
        int b;
        v_cnt = 0; v_first = -1; v_last = -1; busy_fall = -1; ovr_seen = 0;
        for (int c = 0; c < ncyc; c++) begin
            b = c / hold;
            miso_in[0]  = (b < 16) ? w0[15-b] : 1'b0;
            miso_in[1]  = (b < 16) ? w1[15-b] : 1'b0;
            sample_en   = gap ? (c % 2 == 0) : 1'b1;
            frame_start = (c == 2) || (c == fs2);
            tick();
            if (capture_valid) begin
                v_cnt++;
                if (v_first < 0) v_first = c + 1;
                v_last = c + 1;
            end
            if (!busy && c + 1 >= 3 && busy_fall < 0) busy_fall = c + 1;
            if (overrun) ovr_seen = 1;
        end
        frame_start = 1'b0;
    endtask

    function automatic logic [15:0] decim(input logic [W-1:0] v, input int lane);
        logic [15:0] d;
        for (int i = 0; i < 16; i++) d[15-i] = v[lane*LEN + 4*i];
        return d;
    endfunction

    logic [W-1:0] basic_vec;
    logic [W-1:0] ml_vec;
    int           v_after;

    initial begin
        reset_n     = 1'b0;
        frame_start = 1'b0;
        sample_en   = 1'b0;
        miso_in     = '0;
        overrun_clr = 1'b0;
        model_reset();
        #1;
        check("rst_valid", W'(capture_valid), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_overrun", W'(overrun), '0);
        check("rst_miso4x", miso4x, '0);
        tick();
        tick();
        reset_n = 1'b1;
        idle_ticks(4);

        // Basic frame
        run_frame(16'hA5C3, 16'h3C5A, 4, 0, -1, 85);
        check("basic_lat", W'(v_first - 2), W'(74));
        check("basic_vcnt", W'(v_cnt), W'(1));
        check("basic_nib0", W'(miso4x[3:0]), W'(4'hF));
        check("basic_nib1", W'(miso4x[7:4]), W'(4'h0));
        check("basic_dec0", W'(decim(miso4x, 0)), W'(16'hA5C3));
        check("basic_dec1", W'(decim(miso4x, 1)), W'(16'h3C5A));
        check("basic_busyfall", W'(busy_fall), W'(76));
        basic_vec = miso4x;
        idle_ticks(4);

        // Gapped enable
        run_frame(16'hA5C3, 16'h3C5A, 8, 1, -1, 160);
        check("gap_lat", W'(v_first - 2), W'(147));
        check("gap_vcnt", W'(v_cnt), W'(1));
        check("gap_same", miso4x, basic_vec);
        idle_ticks(4);

        // Abort at sample #40
        run_frame(16'hA5C3, 16'h3C5A, 4, 0, 41, 125);
        check("abort_vcnt", W'(v_cnt), W'(1));
        check("abort_vfirst", W'(v_first), W'(115));
        check("abort_busyfall", W'(busy_fall), W'(115));
        check("abort_ovr", W'(overrun), W'(1));
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("abort_clr", W'(overrun), W'(0));
        idle_ticks(4);

        // Back-to-back, second start on sample #74
        run_frame(16'h5A3C, 16'hC3A5, 4, 0, 75, 160);
        check("b2b_vcnt", W'(v_cnt), W'(2));
        check("b2b_vfirst", W'(v_first), W'(76));
        check("b2b_vlast", W'(v_last), W'(150));
        check("b2b_busyfall", W'(busy_fall), W'(150));
        check("b2b_ovr", W'(ovr_seen), W'(0));
        idle_ticks(4);

        // Multi-lane constant words
        run_frame(16'hFFFF, 16'h0000, 4, 0, -1, 85);
        ml_vec = '0;
        ml_vec[63:0] = '1;
        check("multilane", miso4x, ml_vec);
        idle_ticks(4);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            frame_start = ($urandom_range(0, 127) == 0);
            sample_en   = ($urandom_range(0, 3) != 0);
            miso_in     = NL'($urandom);
            overrun_clr = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle_ticks(2);

        // Reset mid-capture
        frame_start = 1'b1;
        miso_in     = '1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            miso_in = NL'($urandom);
            tick();
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_valid", W'(capture_valid), '0);
        check("mid_rst_busy", W'(busy), '0);
        check("mid_rst_overrun", W'(overrun), '0);
        check("mid_rst_miso4x", miso4x, '0);
        tick();
        reset_n = 1'b1;
        v_after = 0;
        for (int i = 0; i < 100; i++) begin
            miso_in = NL'($urandom);
            tick();
            if (capture_valid) v_after++;
        end
        check("mid_rst_novalid", W'(v_after), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
